// File: rtl/regfile_write_arbiter_pkg.sv
// Shared sizing and requester identifiers for the register-file write arbiter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Requester index: ALU writeback is port 0, load unit is port 1.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request handshakes and the register-file write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_waddr, rf_wdata
  );

  // Requester / register-file side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; after every grant it moves to the requester that lost.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  import regfile_pkg::*;

  req_id_e rr_ptr;

  // Grant the lone requester, or the pointed-to one on a tie; nothing in reset.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (rr_ptr == REQ_ALU) ? 2'b01 : 2'b10;
    end
    if (!rst_n) begin
      grant = 2'b00;
    end
  end

  // Point at the non-granted requester after each transfer; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= REQ_ALU;
    end else if (grant[0]) begin
      rr_ptr <= REQ_LSU;
    end else if (grant[1]) begin
      rr_ptr <= REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load-unit writebacks onto one register-file write port and
// tracks which registers still have an outstanding write.
module regfile_write_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave bus,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic [2**ADDR_W-1:0]   pending,
  output logic                   issue_conflict
);

  logic [1:0]          grant;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [2**ADDR_W-1:0] pending_nxt;
  logic                conflict_nxt;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign xfer           = |grant;
  assign sel_addr       = grant[1] ? bus.req1_addr : bus.req0_addr;
  assign sel_data       = grant[1] ? bus.req1_data : bus.req0_data;

  // Scoreboard update: writes retire claims, new claims win a same-cycle tie.
  always_comb begin
    pending_nxt = pending;
    if (xfer) begin
      pending_nxt[sel_addr] = 1'b0;
    end
    if (issue_valid) begin
      pending_nxt[issue_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
    conflict_nxt = issue_valid && (issue_addr != '0) && pending[issue_addr]
                   && !(xfer && (sel_addr == issue_addr));
  end

  // Stage boundary: granted write and scoreboard become visible next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we      <= 1'b0;
      bus.rf_waddr   <= '0;
      bus.rf_wdata   <= '0;
      pending        <= '0;
      issue_conflict <= 1'b0;
    end else begin
      bus.rf_we      <= xfer && (sel_addr != '0);
      if (xfer) begin
        bus.rf_waddr <= sel_addr;
        bus.rf_wdata <= sel_data;
      end
      pending        <= pending_nxt;
      issue_conflict <= conflict_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic [NR-1:0] pending;
  logic          issue_conflict;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .issue_valid    (issue_valid),
    .issue_addr     (issue_addr),
    .pending        (pending),
    .issue_conflict (issue_conflict)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state expected after the next rising edge.
  int            m_fav;
  bit            m_we;
  bit [AW-1:0]   m_waddr;
  bit [DW-1:0]   m_wdata;
  bit [NR-1:0]   m_pend;
  bit            m_conf;

  int            win;
  bit [AW-1:0]   wa;
  bit [DW-1:0]   wd;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_fav = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_pend = '0; m_conf = 0;
    end
    chk("rf_we",    64'(bus.rf_we),    64'(m_we));
    chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
    chk("pending",  64'(pending),      64'(m_pend));
    chk("conflict", 64'(issue_conflict), 64'(m_conf));
    win = -1;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) win = m_fav;
      else if (bus.req0_valid)              win = 0;
      else if (bus.req1_valid)              win = 1;
    end
    chk("req0_ready", 64'(bus.req0_ready), 64'(win == 0));
    chk("req1_ready", 64'(bus.req1_ready), 64'(win == 1));
    if (rst_n) begin
      wa = (win == 1) ? bus.req1_addr : bus.req0_addr;
      wd = (win == 1) ? bus.req1_data : bus.req0_data;
      m_conf = issue_valid && issue_addr != 0 && m_pend[issue_addr]
               && !(win >= 0 && wa == issue_addr);
      m_we = 0;
      if (win >= 0) begin
        m_we    = (wa != 0);
        m_waddr = wa;
        m_wdata = wd;
        m_fav   = 1 - win;
        m_pend[wa] = 1'b0;
      end
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic idle();
    bus.req0_valid = 0; bus.req1_valid = 0; issue_valid = 0;
  endtask

  bit h0, h1, rs;

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
    issue_valid = 0; issue_addr = '0;
    #2;
    // reset state, with a request present
    chk("rst_ready0",  64'(bus.req0_ready), 64'd0);
    chk("rst_we",      64'(bus.rf_we),      64'd0);
    chk("rst_waddr",   64'(bus.rf_waddr),   64'd0);
    chk("rst_pending", 64'(pending),        64'd0);
    chk("rst_conf",    64'(issue_conflict), 64'd0);
    bus.req0_valid = 0;
    step(); step();
    rst_n = 1'b1;
    step();

    // single ALU write
    bus.req0_valid = 1; bus.req0_addr = 5; bus.req0_data = 32'hDEADBEEF;
    #1 chk("w5_ready0", 64'(bus.req0_ready), 64'd1);
    step();
    bus.req0_valid = 0;
    chk("w5_we",    64'(bus.rf_we),    64'd1);
    chk("w5_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("w5_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    chk("model_w5_waddr", 64'(m_waddr), 64'd5);
    step();
    chk("w5_we_off", 64'(bus.rf_we), 64'd0);

    // alternating grants from reset
    do_reset();
    bus.req0_valid = 1; bus.req0_addr = 1; bus.req0_data = 32'h11;
    bus.req1_valid = 1; bus.req1_addr = 2; bus.req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", 64'(bus.req0_ready), 64'((i % 2) == 0));
      chk("rr_ready1", 64'(bus.req1_ready), 64'((i % 2) == 1));
      step();
      chk("rr_waddr", 64'(bus.rf_waddr), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    idle();

    // write to register 0 is accepted but suppressed
    bus.req1_valid = 1; bus.req1_addr = 0; bus.req1_data = 32'h1234;
    #1 chk("r0_ready1", 64'(bus.req1_ready), 64'd1);
    step();
    bus.req1_valid = 0;
    chk("r0_we", 64'(bus.rf_we), 64'd0);
    chk("model_r0_we", 64'(m_we), 64'd0);

    // scoreboard set, clear, and set-wins-over-clear
    issue_valid = 1; issue_addr = 7;
    step();
    issue_valid = 0;
    chk("p7_set", 64'(pending[7]), 64'd1);
    step(); step();
    bus.req0_valid = 1; bus.req0_addr = 7; bus.req0_data = 32'h77;
    step();
    bus.req0_valid = 0;
    chk("p7_clr", 64'(pending[7]), 64'd0);
    issue_valid = 1; issue_addr = 7;
    bus.req0_valid = 1; bus.req0_addr = 7; bus.req0_data = 32'h78;
    step();
    idle();
    chk("p7_setwins", 64'(pending[7]), 64'd1);
    chk("p7_noconf",  64'(issue_conflict), 64'd0);

    // double claim of register 9
    issue_valid = 1; issue_addr = 9;
    step();
    issue_valid = 0;
    chk("c9_n1", 64'(issue_conflict), 64'd0);
    step();
    issue_valid = 1; issue_addr = 9;
    chk("c9_n2", 64'(issue_conflict), 64'd0);
    step();
    issue_valid = 0;
    chk("c9_n3", 64'(issue_conflict), 64'd1);
    chk("model_c9", 64'(m_conf), 64'd1);
    step();
    chk("c9_n4", 64'(issue_conflict), 64'd0);
    chk("p9",    64'(pending[9]),     64'd1);

    // reset in the middle of double-valid traffic
    bus.req0_valid = 1; bus.req0_addr = 3; bus.req0_data = 32'h33;
    bus.req1_valid = 1; bus.req1_addr = 4; bus.req1_data = 32'h44;
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_we",      64'(bus.rf_we),      64'd0);
    chk("mr_waddr",   64'(bus.rf_waddr),   64'd0);
    chk("mr_wdata",   64'(bus.rf_wdata),   64'd0);
    chk("mr_pending", 64'(pending),        64'd0);
    chk("mr_ready0",  64'(bus.req0_ready), 64'd0);
    chk("mr_ready1",  64'(bus.req1_ready), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_first0", 64'(bus.req0_ready), 64'd1);
    chk("mr_first1", 64'(bus.req1_ready), 64'd0);
    step();
    idle();
    chk("mr_waddr3", 64'(bus.rf_waddr), 64'd3);

    // randomized traffic; unaccepted requests are held stable
    h0 = 0; h1 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!h0) begin
        bus.req0_valid = ($urandom_range(0, 99) < 60);
        bus.req0_addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
        bus.req0_data  = $urandom;
      end
      if (!h1) begin
        bus.req1_valid = ($urandom_range(0, 99) < 60);
        bus.req1_addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
        bus.req1_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 99) < 35);
      issue_addr  = AW'($urandom_range(0, 7));
      #1;
      h0 = bus.req0_valid && !bus.req0_ready;
      h1 = bus.req1_valid && !bus.req1_ready;
      rs = ($urandom_range(0, 249) == 0);
      if (rs) begin
        rst_n = 1'b0;
        h0 = 0; h1 = 0;
      end
      step();
      rst_n = 1'b1;
    end
    idle();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width (2**ADDR_W registers).
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  writeback request from ALU (0) / load unit (1).
REQ-006 SHALL have ports req0_addr / req1_addr  input  ADDR_W  destination register.
REQ-007 SHALL have ports req0_data / req1_data  input  DATA_W  write data.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  grant; transfer occurs when valid && ready in the same cycle.
REQ-009 SHALL have port rf_we  output  1  registered write enable to register-file write port.
REQ-010 SHALL have port rf_waddr  output  ADDR_W  registered write address.
REQ-011 SHALL have port rf_wdata  output  DATA_W  registered write data.
REQ-012 SHALL have port issue_valid  input  1  decode claims a destination register for an in-flight instruction.
REQ-013 SHALL have port issue_addr  input  ADDR_W  claimed register.
REQ-014 SHALL have port pending  output  2**ADDR_W  scoreboard; bit r set = register r has an outstanding write.
REQ-015 SHALL have port issue_conflict  output  1  registered one-cycle pulse: claim on an already-pending register.

Function
REQ-016 Arbitration SHALL be round-robin: at most one readyN high per cycle; readyN combinational from valids and rr_ptr only.
REQ-017 Only one valid: that requester SHALL be granted regardless of rr_ptr.
REQ-018 Both valid: requester indexed by rr_ptr SHALL be granted; after any transfer rr_ptr SHALL point to the non-granted requester.
REQ-019 No transfer in a cycle: rr_ptr SHALL hold.
REQ-020 Transfer in cycle N SHALL drive rf_we=1, rf_waddr, rf_wdata with the granted values in cycle N+1 (latency 1); no transfer in N -> rf_we=0 in N+1, rf_waddr/rf_wdata hold.
REQ-021 Transfer with addr 0 SHALL be accepted (ready high) but SHALL produce rf_we=0 in N+1 (register 0 is hard-wired zero).
REQ-022 A requester holding valid with no grant SHALL keep addr/data stable; block never drops an unaccepted request.
REQ-023 issue_valid with issue_addr=r (r!=0) in cycle N SHALL set pending[r] visible in N+1; pending[0] SHALL always be 0.
REQ-024 A transfer to register r in cycle N SHALL clear pending[r] in N+1.
REQ-025 Set and clear of the same register in the same cycle: set SHALL win (pending stays 1).
REQ-026 issue_valid to r with pending[r]=1 and no same-cycle clear of r SHALL pulse issue_conflict for cycle N+1; pending[r] stays 1; otherwise issue_conflict=0.
REQ-027 Transfer to a register with pending=0 SHALL still be written; pending unchanged.
REQ-028 Block SHALL never stall on the write port: register file accepts a write every cycle.

Reset
REQ-029 rst_n low SHALL immediately force rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, issue_conflict=0, rr_ptr=0.
REQ-030 During reset, req0_ready and req1_ready SHALL be 0; no transfer counted.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight registered write (rf_we=0); first grant after release follows REQ-016..018 with rr_ptr=0.

Structure
REQ-032 DATA_W, ADDR_W defaults and NUM_REGS=2**ADDR_W SHALL live in shared package regfile_pkg.
REQ-033 Two-way round-robin grant logic plus rr_ptr SHALL be sub-module rr_arbiter_2; scoreboard and output register stay in top.

Verification
REQ-034 req0 only: addr 5, data 0xDEADBEEF at cycle N -> req0_ready=1 at N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at N+1; rf_we=0 at N+2.
REQ-035 Both valid 4 cycles from reset, addrs 1/2: grants 0,1,0,1; rf_waddr sequence 1,2,1,2 each one cycle later.
REQ-036 req1 writes addr 0, data 0x1234 -> req1_ready=1, rf_we stays 0 next cycle.
REQ-037 issue addr 7 at N -> pending[7]=1 at N+1; req0 transfer addr 7 at N+3 -> pending[7]=0 at N+4; issue addr 7 with transfer addr 7 same cycle -> pending[7] stays 1.
REQ-038 issue addr 9 twice, cycles N and N+2, no write -> issue_conflict=1 only at N+3.
REQ-039 rst_n low mid-transfer with both valid -> outputs, pending zero immediately; after release first double-valid grant goes to req0.
